uart_rx_fifo: RTL

//  Parametrised UART receiver: next generation of the lab UART RX. Adds configurable data width,

---
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, false-start rejection, break detection
// and a first-word-fall-through receive FIFO with valid/ready pop handshake.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_data_in,
   input  logic [1:0]                    parity_type,
   input  logic                          two_stop,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          parity_error,
   output logic                          framing_error,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          overrun,
   input  logic                          overrun_clr,
   output logic                          break_det,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int MID          = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int BW           = $clog2(DATA_BITS);
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int CNTW         = AW + 1;
   localparam int WW           = DATA_BITS + 2;

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
   } state_t;

   state_t state, state_nx;

   logic sync1, sync2, line_prev, fall;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync1     <= serial_data_in;
         sync2     <= sync1;
         line_prev <= sync2;
      end
   end

   assign fall = line_prev & ~sync2;

   logic [CW-1:0]        cnt;
   logic                 samp_a, samp_b, vote;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, ferr_q, two_cfg;
   logic [1:0]           par_cfg;
   logic                 bit_end, decide, par_en, last_data, is_break;

   assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
   assign decide    = (cnt == CW'(MID + 1));
   assign vote      = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
   assign par_en    = (par_cfg == 2'd1) || (par_cfg == 2'd2);
   assign last_data = (bit_idx == BW'(DATA_BITS - 1));
   // A break is an all-zero frame body whose first stop bit is also low.
   assign is_break  = ~vote && (shreg == '0) && (!par_en || !par_bit);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (fall) state_nx = START;
         START:    if (decide && vote) state_nx = IDLE;
                   else if (bit_end)   state_nx = DATA;
         DATA:     if (bit_end && last_data) state_nx = par_en ? PARITY : STOP1;
         PARITY:   if (bit_end) state_nx = STOP1;
         STOP1:    if (decide && is_break)      state_nx = BRK_WAIT;
                   else if (decide && !two_cfg) state_nx = IDLE;
                   else if (bit_end)            state_nx = STOP2;
         STOP2:    if (decide) state_nx = IDLE;
         BRK_WAIT: if (sync2) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   logic push, brk_hit, cfg_load, word_ferr, word_perr;

   always_comb begin
      push      = 1'b0;
      brk_hit   = 1'b0;
      cfg_load  = 1'b0;
      word_ferr = 1'b0;
      case (state)
         START: cfg_load = decide && !vote;
         STOP1: if (decide) begin
            brk_hit   = is_break;
            push      = !is_break && !two_cfg;
            word_ferr = ~vote;
         end
         STOP2: if (decide) begin
            push      = 1'b1;
            word_ferr = ferr_q | ~vote;
         end
         default: ;
      endcase
   end

   assign word_perr = par_en && ((^shreg ^ par_bit) != (par_cfg == 2'd1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         samp_a    <= 1'b1;
         samp_b    <= 1'b1;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         ferr_q    <= 1'b0;
         par_cfg   <= 2'd0;
         two_cfg   <= 1'b0;
         break_det <= 1'b0;
      end else begin
         break_det <= brk_hit;
         if (state == IDLE || state == BRK_WAIT || bit_end) cnt <= '0;
         else                                               cnt <= cnt + CW'(1);
         if (cnt == CW'(MID - 1)) samp_a <= sync2;
         if (cnt == CW'(MID))     samp_b <= sync2;
         if (cfg_load) begin
            par_cfg <= parity_type;
            two_cfg <= two_stop;
         end
         if (state == START) begin
            bit_idx <= '0;
            ferr_q  <= 1'b0;
         end
         if (state == DATA && decide)  shreg   <= {vote, shreg[DATA_BITS-1:1]};
         if (state == DATA && bit_end) bit_idx <= bit_idx + BW'(1);
         if (state == PARITY && decide) par_bit <= vote;
         if (state == STOP1 && decide)  ferr_q  <= ~vote;
      end
   end

   logic [WW-1:0]   mem [FIFO_DEPTH];
   logic [WW-1:0]   head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            full, pop, do_push, ovr_set;

   assign full    = (count == CNTW'(FIFO_DEPTH));
   assign rx_valid = (count != '0);
   assign pop     = rx_valid && rx_ready;
   assign do_push = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   // NOTE: storage is left unreset; only pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {word_ferr, word_perr, shreg};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: ;
         endcase
         if (ovr_set)          overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

   assign head          = mem[rd_ptr];
   assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign parity_error  = rx_valid & head[DATA_BITS];
   assign framing_error = rx_valid & head[DATA_BITS+1];
   assign fifo_count    = count;

endmodule
